s2a_axi_arbiter: RTL and testbench
==================================

Name: s2a_axi_arbiter

Overview:
- Shares one AXI write-address and write-data channel (towards OCM) between NREQ stream-to-AXI burst writers.
- Grants a whole burst to one requester: AW handshake, then W beats through WLAST. Requesters are selected round-robin.
- Drives a grant index that the top level uses to mux write data.
- Keeps burst statistics and flags bursts that are too long.

Parameters:
- NREQ, 2, number of requesters (2..4).
- GW, 2, grant index width (≥ clog2(NREQ)).
- MAX_BEATS, 16, beats allowed per burst before burst_err is raised.

Ports:
- AXI_clk  in  1  single clock for the whole block.
- rst  in  1  synchronous active-high reset.
- S_awaddr  in  32*NREQ  per-requester write address (requester i at bits [32i+31:32i]).
- S_awvalid  in  NREQ  per-requester address valid.
- S_awready  out  NREQ  per-requester address ready.
- S_wvalid  in  NREQ  per-requester data valid.
- S_wlast  in  NREQ  per-requester last beat.
- S_wready  out  NREQ  per-requester data ready.
- AXI_awaddr  out  32  to OCM port.
- AXI_awvalid  out  1  to OCM port.
- AXI_awready  in  1  from OCM port.
- AXI_wvalid  out  1  to OCM port.
- AXI_wlast  out  1  to OCM port.
- AXI_wready  in  1  from OCM port.
- grant_id  out  GW  index of the owning requester; selects the write-data mux.
- busy  out  1  high in states ADDR and DATA.
- burst_cnt  out  32  number of completed bursts.
- burst_err  out  1  sticky over-length flag.

Behaviour:
- Reset (synchronous, rst=1 at a rising AXI_clk edge):
  - state=IDLE; grant_id=0; last_grant=NREQ-1; beat count=0; burst_cnt=0; burst_err=0.
  - All ready/valid outputs are 0 combinationally whenever state=IDLE.
  - Reset mid-burst abandons the burst immediately; the next cycle shows no valid and no ready.
- State IDLE:
  - If any S_awvalid is set, pick the first asserted requester searching from last_grant+1 upward, modulo NREQ.
  - Register grant_id and go to ADDR. Arbitration latency is 1 cycle.
  - If no S_awvalid is set, stay in IDLE.
- State ADDR (g = grant_id):
  - AXI_awvalid = S_awvalid[g]; AXI_awaddr = S_awaddr[g].
  - S_awready[g] = AXI_awready; all other S_awready bits are 0.
  - On AXI_awvalid & AXI_awready: go to DATA and clear the beat count.
  - If S_awvalid[g] drops before the handshake (protocol violation): return to IDLE and set last_grant=g.
- State DATA:
  - AXI_wvalid = S_wvalid[g]; AXI_wlast = S_wlast[g].
  - S_wready[g] = AXI_wready; all other S_wready bits are 0.
  - Each W handshake increments the beat count (saturating).
  - Handshake with wlast=1: go to IDLE, last_grant=g, burst_cnt+1 (wraps at 2^32).
  - Handshake with wlast=0 when the beat count is already MAX_BEATS-1: set burst_err; the burst continues until wlast.
- AXI_awaddr:
  - Reads 0 when state≠ADDR.
  - No combinational path from AXI_*ready to AXI_*valid.
- Simultaneous requests resolve strictly round-robin. A requester that asserts while another burst is in flight waits; no requester is pre-empted.
- A new address from the same requester is accepted only after returning to IDLE. There is at least 1 idle cycle between bursts.
- Ungranted requesters see ready=0 and must hold their valid.

Decomposition:
- Shared package s2a_pkg holds:
  - the state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - OCM_HADDR=32'hfffc0000;
  - the default MAX_BEATS.
- One sub-module, s2a_rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are the chosen index and a valid flag.
- The rest of the block is the FSM, the muxes and the counters.

Test Plan:
- Single burst: only req0 asserts awvalid with awaddr=0xfffc0040, then 16 beats, wlast on beat 16 -> AXI_awaddr=0xfffc0040 for one handshake; 16 W beats forwarded; burst_cnt=1; grant_id=0; busy low afterwards.
- Contention: req0 and req1 assert awvalid in the same cycle after reset -> req0 is served first (last_grant=1 at reset), then req1; repeated three times gives order 0,1,0,1,0,1.
- Backpressure: AXI_wready toggles 1010…, 16 beats -> S_wready[g] mirrors AXI_wready; exactly 16 beats counted; no beats forwarded to the ungranted requester.
- Over-length burst: 18 beats, wlast on beat 18 -> burst_err=1 from the 16th non-last handshake; burst completes; burst_cnt increments; burst_err stays set until rst.
- Mid-burst reset: rst asserted at beat 5 -> the next cycle has all valid/ready outputs 0, burst_cnt=0, state IDLE; a new burst then completes normally.
- awvalid withdrawn: req1 drops awvalid while AXI_awready=0 -> return to IDLE; a pending req0 is granted next; burst_cnt unchanged.

Source files
------------

// File: rtl/s2a_pkg.sv
// Shared definitions for the stream-to-AXI write arbiter.
package s2a_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } s2a_state_e;

    // Base of the OCM high address window the writers target
    localparam logic [31:0] OCM_HADDR = 32'hfffc0000;

    // Default number of beats a burst may carry before it is flagged
    localparam int S2A_MAX_BEATS = 16;

endpackage

// File: rtl/s2a_rr_pick.sv
// Combinational round-robin picker: first request strictly after
// last_grant, wrapping back to index 0.
module s2a_rr_pick
    import s2a_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   pick_idx,
    output logic            pick_vld
);

    logic [NREQ-1:0] upper_s;
    logic [NREQ-1:0] upper_req_s;
    logic [GW-1:0]   upper_idx_s;
    logic [GW-1:0]   any_idx_s;

    // Mark requesters whose index lies above the last winner
    always_comb begin
        upper_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_s[i] = (GW'(i) > last_grant);
        end
    end

    assign upper_req_s = req & upper_s;

    // Lowest request above last_grant wins, otherwise wrap to the lowest request
    always_comb begin
        upper_idx_s = '0;
        any_idx_s   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            upper_idx_s = upper_req_s[i] ? GW'(i) : upper_idx_s;
            any_idx_s   = req[i]         ? GW'(i) : any_idx_s;
        end
        if (|upper_req_s) begin
            pick_idx = upper_idx_s;
        end else begin
            pick_idx = any_idx_s;
        end
        pick_vld = |req;
    end

endmodule

// File: rtl/s2a_axi_arbiter.sv
// Burst-level round-robin arbiter sharing one AXI AW/W channel pair
// between NREQ stream-to-AXI writers, with burst statistics.
module s2a_axi_arbiter
    import s2a_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int GW        = 2,
    parameter int MAX_BEATS = S2A_MAX_BEATS
) (
    input  logic                 AXI_clk,
    input  logic                 rst,
    input  logic [32*NREQ-1:0]   S_awaddr,
    input  logic [NREQ-1:0]      S_awvalid,
    output logic [NREQ-1:0]      S_awready,
    input  logic [NREQ-1:0]      S_wvalid,
    input  logic [NREQ-1:0]      S_wlast,
    output logic [NREQ-1:0]      S_wready,
    output logic [31:0]          AXI_awaddr,
    output logic                 AXI_awvalid,
    input  logic                 AXI_awready,
    output logic                 AXI_wvalid,
    output logic                 AXI_wlast,
    input  logic                 AXI_wready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [31:0]          burst_cnt,
    output logic                 burst_err
);

    localparam int BW = $clog2(MAX_BEATS) + 1;

    s2a_state_e     state_r, state_n_s;
    logic [GW-1:0]  grant_r, grant_n_s;
    logic [GW-1:0]  last_grant_r, last_grant_n_s;
    logic [BW-1:0]  beat_cnt_r, beat_cnt_n_s;
    logic [31:0]    burst_cnt_r, burst_cnt_n_s;
    logic           burst_err_r, burst_err_n_s;

    logic [GW-1:0]   pick_idx_s;
    logic            pick_vld_s;
    logic [NREQ-1:0] gsel_s;
    logic [31:0]     addr_sel_s;
    logic            awvalid_g_s;
    logic            aw_hs_s;
    logic            w_hs_s;

    s2a_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req        (S_awvalid),
        .last_grant (last_grant_r),
        .pick_idx   (pick_idx_s),
        .pick_vld   (pick_vld_s)
    );

    // One-hot decode of the current owner and its address
    always_comb begin
        gsel_s     = '0;
        addr_sel_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            gsel_s[i]  = (grant_r == GW'(i));
            addr_sel_s = addr_sel_s | (S_awaddr[32*i +: 32] & {32{grant_r == GW'(i)}});
        end
    end

    assign awvalid_g_s = |(S_awvalid & gsel_s);

    // Forward the owner's valids and route the OCM readies back to it only
    always_comb begin
        AXI_awvalid = 1'b0;
        AXI_awaddr  = 32'd0;
        S_awready   = '0;
        AXI_wvalid  = 1'b0;
        AXI_wlast   = 1'b0;
        S_wready    = '0;
        case (state_r)
            ADDR: begin
                AXI_awvalid = awvalid_g_s;
                AXI_awaddr  = addr_sel_s;
                S_awready   = AXI_awready ? gsel_s : '0;
            end
            DATA: begin
                AXI_wvalid = |(S_wvalid & gsel_s);
                AXI_wlast  = |(S_wlast & gsel_s);
                S_wready   = AXI_wready ? gsel_s : '0;
            end
            default: begin
                AXI_awvalid = 1'b0;
            end
        endcase
    end

    assign aw_hs_s = AXI_awvalid & AXI_awready;
    assign w_hs_s  = AXI_wvalid & AXI_wready;

    // Next-state, grant bookkeeping and burst statistics
    always_comb begin
        state_n_s      = state_r;
        grant_n_s      = grant_r;
        last_grant_n_s = last_grant_r;
        beat_cnt_n_s   = beat_cnt_r;
        burst_cnt_n_s  = burst_cnt_r;
        burst_err_n_s  = burst_err_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    grant_n_s = pick_idx_s;
                    state_n_s = ADDR;
                end else begin
                    state_n_s = IDLE;
                end
            end
            ADDR: begin
                if (aw_hs_s) begin
                    state_n_s    = DATA;
                    beat_cnt_n_s = '0;
                end else if (!awvalid_g_s) begin
                    // requester withdrew its address: give up the slot
                    state_n_s      = IDLE;
                    last_grant_n_s = grant_r;
                end else begin
                    state_n_s = ADDR;
                end
            end
            DATA: begin
                if (w_hs_s) begin
                    beat_cnt_n_s = (beat_cnt_r == {BW{1'b1}}) ? beat_cnt_r
                                                              : beat_cnt_r + BW'(1);
                    if (AXI_wlast) begin
                        state_n_s      = IDLE;
                        last_grant_n_s = grant_r;
                        burst_cnt_n_s  = burst_cnt_r + 32'd1;
                    end else if (beat_cnt_r == BW'(MAX_BEATS - 1)) begin
                        // one beat beyond the limit and still no wlast
                        burst_err_n_s = 1'b1;
                    end else begin
                        burst_err_n_s = burst_err_r;
                    end
                end else begin
                    state_n_s = DATA;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State and statistics registers with synchronous reset
    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(NREQ - 1);
            beat_cnt_r   <= '0;
            burst_cnt_r  <= 32'd0;
            burst_err_r  <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            grant_r      <= grant_n_s;
            last_grant_r <= last_grant_n_s;
            beat_cnt_r   <= beat_cnt_n_s;
            burst_cnt_r  <= burst_cnt_n_s;
            burst_err_r  <= burst_err_n_s;
        end
    end

    assign grant_id  = grant_r;
    assign busy      = (state_r == ADDR) || (state_r == DATA);
    assign burst_cnt = burst_cnt_r;
    assign burst_err = burst_err_r;

endmodule

// File: tb/tb_s2a_axi_arbiter.sv
// Directed bench for s2a_axi_arbiter: single burst, contention,
// backpressure, over-length, mid-burst reset and address withdrawal.
module tb_s2a_axi_arbiter;

    localparam int NREQ      = 2;
    localparam int GW        = 2;
    localparam int MAX_BEATS = 16;

    logic                AXI_clk;
    logic                rst;
    logic [32*NREQ-1:0]  S_awaddr;
    logic [NREQ-1:0]     S_awvalid;
    logic [NREQ-1:0]     S_awready;
    logic [NREQ-1:0]     S_wvalid;
    logic [NREQ-1:0]     S_wlast;
    logic [NREQ-1:0]     S_wready;
    logic [31:0]         AXI_awaddr;
    logic                AXI_awvalid;
    logic                AXI_awready;
    logic                AXI_wvalid;
    logic                AXI_wlast;
    logic                AXI_wready;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic [31:0]         burst_cnt;
    logic                burst_err;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cnt_exp    = 0;
    bit err_exp    = 1'b0;

    s2a_axi_arbiter #(
        .NREQ      (NREQ),
        .GW        (GW),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .AXI_clk     (AXI_clk),
        .rst         (rst),
        .S_awaddr    (S_awaddr),
        .S_awvalid   (S_awvalid),
        .S_awready   (S_awready),
        .S_wvalid    (S_wvalid),
        .S_wlast     (S_wlast),
        .S_wready    (S_wready),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wlast   (AXI_wlast),
        .AXI_wready  (AXI_wready),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_cnt   (burst_cnt),
        .burst_err   (burst_err)
    );

    initial begin
        AXI_clk = 1'b0;
        forever #5 AXI_clk = ~AXI_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXI_clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        S_awvalid   = '0;
        S_wvalid    = '0;
        S_wlast     = '0;
        AXI_awready = 1'b0;
        AXI_wready  = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        cnt_exp = 0;
        err_exp = 1'b0;
    endtask

    // One complete burst from requester r; entered and left at posedge+1.
    // rst_at >= 0 asserts rst once that many beats have been accepted.
    task automatic do_burst(input int r, input logic [31:0] addr, input int nbeats,
                            input bit toggle, input int rst_at);
        bit got_aw;
        bit hs;
        bit was_last;
        int beats;
        int cyc;
        S_awaddr[32*r +: 32] = addr;
        S_awvalid[r]         = 1'b1;
        AXI_awready          = 1'b1;
        got_aw = 1'b0;
        for (int c = 0; c < 20 && !got_aw; c++) begin
            #1;
            if (AXI_awvalid && S_awready[r]) begin
                got_aw = 1'b1;
                chk("aw_addr", AXI_awaddr, addr);
                chk("aw_grant", 32'(grant_id), 32'(r));
            end
            tick();
        end
        if (!got_aw) chk("aw_timeout", 32'd0, 32'd1);
        S_awvalid[r] = 1'b0;
        AXI_awready  = 1'b0;

        beats       = 0;
        cyc         = 0;
        S_wvalid[r] = 1'b1;
        S_wlast[r]  = (nbeats == 1);
        while (beats < nbeats && cyc < 200) begin
            AXI_wready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (beats == rst_at) begin
                rst = 1'b1;
                tick();
                rst     = 1'b0;
                cnt_exp = 0;
                err_exp = 1'b0;
                #1;
                chk("rst_awvalid", 32'(AXI_awvalid), 32'd0);
                chk("rst_wvalid", 32'(AXI_wvalid), 32'd0);
                chk("rst_wready", 32'(S_wready), 32'd0);
                chk("rst_awready", 32'(S_awready), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_cnt", burst_cnt, 32'd0);
                chk("rst_grant", 32'(grant_id), 32'd0);
                S_wvalid[r] = 1'b0;
                S_wlast[r]  = 1'b0;
                AXI_wready  = 1'b0;
                tick();
                return;
            end
            #1;
            chk("wready_mirror", 32'(S_wready[r]), 32'(AXI_wready));
            chk("wready_other", 32'(S_wready & ~(2'b01 << r)), 32'd0);
            chk("wvalid", 32'(AXI_wvalid), 32'd1);
            chk("wlast", 32'(AXI_wlast), 32'(beats == nbeats - 1));
            chk("awaddr_data", AXI_awaddr, 32'd0);
            chk("burst_err", 32'(burst_err), 32'(err_exp));
            hs       = AXI_wvalid && AXI_wready;
            was_last = (beats == nbeats - 1);
            tick();
            if (hs) begin
                if (!was_last && beats >= MAX_BEATS - 1) err_exp = 1'b1;
                beats++;
                S_wlast[r] = (beats == nbeats - 1);
            end
            cyc++;
        end
        S_wvalid[r] = 1'b0;
        S_wlast[r]  = 1'b0;
        AXI_wready  = 1'b0;
        chk("beat_total", 32'(beats), 32'(nbeats));
        if (beats == nbeats) cnt_exp++;
        chk("burst_cnt", burst_cnt, 32'(cnt_exp));
        chk("busy_after", 32'(busy), 32'd0);
        chk("err_after", 32'(burst_err), 32'(err_exp));
    endtask

    initial begin
        rst       = 1'b1;
        S_awaddr  = '0;
        S_awvalid = '0;
        S_wvalid  = '0;
        S_wlast   = '0;
        AXI_awready = 1'b0;
        AXI_wready  = 1'b0;
        do_reset();

        // Reset state
        #1;
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_burst_cnt", burst_cnt, 32'd0);
        chk("rst_burst_err", 32'(burst_err), 32'd0);
        chk("rst_awaddr", AXI_awaddr, 32'd0);

        // Outputs stay quiet in IDLE even with a request present
        S_awaddr[31:0] = 32'hfffc0040;
        S_awvalid[0]   = 1'b1;
        AXI_awready    = 1'b1;
        #1;
        chk("idle_awvalid", 32'(AXI_awvalid), 32'd0);
        chk("idle_awready", 32'(S_awready), 32'd0);
        chk("idle_awaddr", AXI_awaddr, 32'd0);
        tick();

        // Single 16-beat burst from requester 0
        do_burst(0, 32'hfffc0040, 16, 1'b0, -1);
        chk("single_grant", 32'(grant_id), 32'd0);
        chk("single_err", 32'(burst_err), 32'd0);

        // Contention: both request together, order must be 0,1,0,1,0,1
        do_reset();
        S_awaddr[63:32] = 32'hfffc0200;
        S_awvalid       = 2'b11;
        for (int k = 0; k < 3; k++) begin
            do_burst(0, 32'hfffc0100 + 32'(k), 4, 1'b0, -1);
            S_awvalid[0] = 1'b1;
            do_burst(1, 32'hfffc0200 + 32'(k), 4, 1'b0, -1);
            S_awvalid[1] = (k < 2);
            S_awvalid[0] = (k < 2);
        end
        chk("contention_cnt", burst_cnt, 32'd6);

        // Backpressure: wready toggling 1010... on a 16-beat burst
        do_burst(1, 32'hfffc0300, 16, 1'b1, -1);

        // Over-length: 18 beats, error raised on the 16th non-last beat
        do_burst(0, 32'hfffc0400, 18, 1'b0, -1);
        chk("overlen_err", 32'(burst_err), 32'd1);
        do_burst(1, 32'hfffc0500, 2, 1'b0, -1);
        chk("err_sticky", 32'(burst_err), 32'd1);
        chk("cnt_after_err", burst_cnt, 32'd9);

        // Mid-burst reset during beat 5, then a clean burst
        do_burst(0, 32'hfffc0600, 16, 1'b0, 4);
        chk("post_rst_err", 32'(burst_err), 32'd0);
        do_burst(0, 32'hfffc0700, 4, 1'b0, -1);
        chk("post_rst_cnt", burst_cnt, 32'd1);

        // awvalid withdrawal: req1 wins, drops awvalid, req0 is served next
        S_awaddr[31:0]  = 32'hfffc0800;
        S_awaddr[63:32] = 32'hfffc0900;
        S_awvalid       = 2'b11;
        AXI_awready     = 1'b0;
        tick();
        #1;
        chk("wd_grant", 32'(grant_id), 32'd1);
        chk("wd_awvalid", 32'(AXI_awvalid), 32'd1);
        chk("wd_awaddr", AXI_awaddr, 32'hfffc0900);
        chk("wd_awready", 32'(S_awready), 32'd0);
        S_awvalid[1] = 1'b0;
        #1;
        chk("wd_awvalid_drop", 32'(AXI_awvalid), 32'd0);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_cnt", burst_cnt, 32'd1);
        do_burst(0, 32'hfffc0800, 3, 1'b0, -1);
        chk("wd_cnt_final", burst_cnt, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
